// File: rtl/av2_coeff_rle_decoder_pkg.sv
// Shared token encodings, decoder states and the signed saturate helper
// for the coefficient RLE decoder.
package av2_coeff_pkg;

  typedef enum logic [1:0] {
    TOK_LEVEL = 2'b00,
    TOK_RUN   = 2'b01,
    TOK_EOB   = 2'b10,
    TOK_RSVD  = 2'b11
  } tok_t;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PARSE,
    DRAIN,
    DONE
  } state_t;

  localparam int LEVEL_W = 14;
  localparam int RUN_W   = 12;
  localparam int PROD_W  = 31;

  // Clamp a PROD_W-bit signed value into the signed range of a w-bit word.
  function automatic logic signed [PROD_W-1:0] sat_signed(input logic signed [PROD_W-1:0] v,
                                                          input int w);
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    hi = PROD_W'((1 << (w - 1)) - 1);
    lo = -hi - PROD_W'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/av2_coeff_rle_decoder_scan_addr.sv
// Scan index to raster address map: identity for raster scan, transpose
// of the N x N block for column scan.
module av2_coeff_scan_addr
  import av2_coeff_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] idx,
  input  logic [2:0]    tx_log2,
  input  logic          scan_col,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] mask;

  assign mask = (AW'(1) << tx_log2) - AW'(1);
  assign addr = scan_col ? (((idx & mask) << tx_log2) | (idx >> tx_log2)) : idx;

endmodule

// File: rtl/av2_coeff_rle_decoder.sv
// Token-to-block coefficient decoder with a self-clearing store streamed out in raster order.
// Optional dequant multiply/saturate in the output path: AV2_COEFF_DEQUANT_EN.
module av2_coeff_rle_decoder
  import av2_coeff_pkg::*;
#(
  parameter int COEFF_W  = 16,
  parameter int MAX_LOG2 = 6,
  parameter int AW       = 2 * MAX_LOG2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2:0]                tx_log2,
  input  logic                      scan_col,
  input  logic [15:0]               dq_step,
  input  logic [15:0]               sym_data,
  input  logic                      sym_valid,
  output logic                      sym_ready,
  output logic signed [COEFF_W-1:0] coeff_data,
  output logic [AW-1:0]             coeff_addr,
  output logic                      coeff_valid,
  input  logic                      coeff_ready,
  output logic                      coeff_last,
  output logic [AW:0]               eob_pos,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  // state | meaning
  // CLEAR | zero every store entry after reset
  // IDLE  | wait for start
  // PARSE | consume tokens, write levels
  // DRAIN | stream raster block out, zeroing behind the read
  // DONE  | one-cycle completion pulse

  localparam int SW = AW + RUN_W + 1;

  state_t                    state;
  logic [2:0]                log2_q, tx_clamped;
  logic                      col_q;
  logic [AW:0]               idx, nn, nn_m1, parse_idx;
  logic                      parse_end, parse_err;
  logic [SW-1:0]             idx_run;
  tok_t                      tok_type;
  logic [AW-1:0]             clr_cnt, drn_cnt, scan_addr, ram_addr, rd_addr;
  logic                      drn_pend, drn_last, rd_en, rd_adv, out_adv, ram_we;
  logic                      rd_vld, rd_last;
  logic signed [COEFF_W-1:0] ram_wdata, rd_data;
  logic signed [COEFF_W-1:0] mem [2**AW];

  assign nn        = (AW+1)'(1) << {log2_q, 1'b0};
  assign nn_m1     = nn - (AW+1)'(1);
  assign drn_last  = ({1'b0, drn_cnt} == nn_m1);
  assign tok_type  = tok_t'(sym_data[15:14]);
  assign idx_run   = SW'(idx) + SW'(sym_data[RUN_W-1:0]);
  assign busy      = (state != IDLE);
  assign sym_ready = (state == PARSE);
  assign done      = (state == DONE);
  assign rd_en     = (state == DRAIN) && drn_pend && rd_adv;

  always_comb begin
    tx_clamped = tx_log2;
    if (tx_log2 < 3'd2) tx_clamped = 3'd2;
    else if (int'(tx_log2) > MAX_LOG2) tx_clamped = 3'(MAX_LOG2);
  end

  always_comb begin
    parse_idx = idx;
    parse_end = 1'b0;
    parse_err = 1'b0;
    case (tok_type)
      TOK_LEVEL: begin
        parse_idx = idx + (AW+1)'(1);
        parse_end = (parse_idx == nn);
      end
      TOK_RUN: begin
        if (idx_run > SW'(nn)) begin
          parse_idx = nn;
          parse_end = 1'b1;
          parse_err = 1'b1;
        end else begin
          parse_idx = idx_run[AW:0];
          parse_end = (idx_run == SW'(nn));
        end
      end
      TOK_EOB:  parse_end = 1'b1;
      default: begin
        parse_end = 1'b1;
        parse_err = 1'b1;
      end
    endcase
  end

  av2_coeff_scan_addr #(.AW(AW)) u_scan_addr (
    .idx      (idx[AW-1:0]),
    .tx_log2  (log2_q),
    .scan_col (col_q),
    .addr     (scan_addr)
  );

  // One store access per cycle; DRAIN reads and zeroes the same entry (read-first).
  always_comb begin
    ram_addr  = drn_cnt;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state)
      CLEAR: begin
        ram_addr = clr_cnt;
        ram_we   = 1'b1;
      end
      PARSE: begin
        ram_addr  = scan_addr;
        ram_we    = sym_valid && (tok_type == TOK_LEVEL);
        ram_wdata = COEFF_W'($signed(sym_data[LEVEL_W-1:0]));
      end
      DRAIN:   ram_we = rd_en;
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (rd_en) rd_data <= mem[ram_addr];
  end

  assign out_adv = !coeff_valid || coeff_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_addr <= '0;
      rd_last <= 1'b0;
    end else if (rd_adv) begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_addr <= drn_cnt;
        rd_last <= drn_last;
      end
    end
  end

`ifdef AV2_COEFF_DEQUANT_EN
  logic                     m_vld, m_last, m_adv;
  logic [AW-1:0]            m_addr;
  logic signed [PROD_W-1:0] m_prod;
  logic [15:0]              dq_q;

  assign m_adv  = !m_vld || out_adv;
  assign rd_adv = !rd_vld || m_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld       <= 1'b0;
      m_last      <= 1'b0;
      m_addr      <= '0;
      m_prod      <= '0;
      coeff_valid <= 1'b0;
      coeff_data  <= '0;
      coeff_addr  <= '0;
      coeff_last  <= 1'b0;
    end else begin
      if (m_adv) begin
        m_vld <= rd_vld;
        if (rd_vld) begin
          m_prod <= PROD_W'(rd_data) * PROD_W'($signed({1'b0, dq_q}));
          m_addr <= rd_addr;
          m_last <= rd_last;
        end
      end
      if (out_adv) begin
        coeff_valid <= m_vld;
        coeff_last  <= m_vld && m_last;
        if (m_vld) begin
          coeff_data <= COEFF_W'(sat_signed(m_prod, COEFF_W));
          coeff_addr <= m_addr;
        end
      end
    end
  end
`else
  logic unused_dq;

  assign unused_dq = ^dq_step;
  assign rd_adv    = !rd_vld || out_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coeff_valid <= 1'b0;
      coeff_data  <= '0;
      coeff_addr  <= '0;
      coeff_last  <= 1'b0;
    end else if (out_adv) begin
      coeff_valid <= rd_vld;
      coeff_last  <= rd_vld && rd_last;
      if (rd_vld) begin
        coeff_data <= rd_data;
        coeff_addr <= rd_addr;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_cnt  <= '1;
      log2_q   <= 3'd2;
      col_q    <= 1'b0;
      idx      <= '0;
      eob_pos  <= '0;
      err      <= 1'b0;
      drn_cnt  <= '0;
      drn_pend <= 1'b0;
`ifdef AV2_COEFF_DEQUANT_EN
      dq_q     <= '0;
`endif
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt - AW'(1);
          if (clr_cnt == '0) state <= IDLE;
        end
        IDLE: begin
          if (start) begin
            log2_q <= tx_clamped;
            col_q  <= scan_col;
            idx    <= '0;
            err    <= 1'b0;
`ifdef AV2_COEFF_DEQUANT_EN
            dq_q   <= dq_step;
`endif
            state  <= PARSE;
          end
        end
        PARSE: begin
          if (sym_valid) begin
            idx <= parse_idx;
            if (parse_err) err <= 1'b1;
            if (parse_end) begin
              eob_pos  <= parse_idx;
              drn_cnt  <= '0;
              drn_pend <= 1'b1;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (rd_en) begin
            if (drn_last) drn_pend <= 1'b0;
            else drn_cnt <= drn_cnt + AW'(1);
          end
          if (coeff_valid && coeff_ready && coeff_last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_av2_coeff_rle_decoder.sv
// Randomized bench for av2_coeff_rle_decoder against a token-level block model.
module tb_av2_coeff_rle_decoder;

  localparam int COEFF_W  = 16;
  localparam int MAX_LOG2 = 6;
  localparam int AW       = 2 * MAX_LOG2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [2:0]                tx_log2 = '0;
  logic                      scan_col = 1'b0;
  logic [15:0]               dq_step = '0;
  logic [15:0]               sym_data = '0;
  logic                      sym_valid = 1'b0;
  logic                      sym_ready;
  logic signed [COEFF_W-1:0] coeff_data;
  logic [AW-1:0]             coeff_addr;
  logic                      coeff_valid;
  logic                      coeff_ready = 1'b0;
  logic                      coeff_last;
  logic [AW:0]               eob_pos;
  logic                      busy;
  logic                      done;
  logic                      err;

  av2_coeff_rle_decoder #(.COEFF_W(COEFF_W), .MAX_LOG2(MAX_LOG2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tx_log2     (tx_log2),
    .scan_col    (scan_col),
    .dq_step     (dq_step),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .coeff_data  (coeff_data),
    .coeff_addr  (coeff_addr),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeff_last  (coeff_last),
    .eob_pos     (eob_pos),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] tq[$];
  int          exp_mem[4096];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tok_lvl(input int v);
    logic [13:0] p;
    p = 14'(v);
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] tok_run(input int r);
    logic [11:0] p;
    p = 12'(r);
    return {4'b0100, p};
  endfunction

  localparam logic [15:0] TOK_EOB_W  = 16'h8000;
  localparam logic [15:0] TOK_RSVD_W = 16'hC000;

  function automatic int expect_coeff(input int lvl, input int dq);
`ifdef AV2_COEFF_DEQUANT_EN
    longint p;
    p = longint'(lvl) * longint'(dq);
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return int'(p);
`else
    return lvl + 0 * dq;
`endif
  endfunction

  task automatic gen_tokens(input int n);
    int k;
    tq.delete();
    k = $urandom_range(n * n / 2 + 2, 1);
    for (int i = 0; i < k; i++) begin
      if ($urandom_range(9) < 7) tq.push_back(tok_lvl(int'($urandom_range(16383)) - 8192));
      else tq.push_back(tok_run(int'($urandom_range(n))));
    end
    tq.push_back(TOK_EOB_W);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 0);
  endtask

  task automatic run_block(input int lg_in, input bit col, input int dq, input int rdy_pct,
                           input string name);
    int          lg, n, nn, idx, consumed, err_e, pos, pl, r, ti, done_cnt;
    int          bq_addr[$], bq_data[$], bq_last[$];
    logic [15:0] tk;
    bit          stall, fin;
    longint      held;
    lg = (lg_in < 2) ? 2 : ((lg_in > MAX_LOG2) ? MAX_LOG2 : lg_in);
    n = 1 << lg;
    nn = n * n;
    foreach (exp_mem[i]) exp_mem[i] = 0;
    idx = 0; consumed = 0; err_e = 0;
    for (int t = 0; t < tq.size(); t++) begin
      tk = tq[t];
      consumed++;
      if (tk[15:14] == 2'b00) begin
        pl = int'($signed(tk[13:0]));
        pos = col ? ((idx % n) * n + idx / n) : idx;
        exp_mem[pos] = expect_coeff(pl, dq);
        idx++;
        if (idx == nn) break;
      end else if (tk[15:14] == 2'b01) begin
        r = int'(tk[11:0]);
        if (idx + r > nn) begin
          err_e = 1;
          idx = nn;
          break;
        end
        idx += r;
        if (idx == nn) break;
      end else if (tk[15:14] == 2'b10) begin
        break;
      end else begin
        err_e = 1;
        break;
      end
    end

    @(negedge clk);
    tx_log2 = 3'(lg_in); scan_col = col; dq_step = 16'(dq); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_ready_after_start"}, sym_ready, 1);
    check({name, "_err_cleared"}, err, 0);

    ti = 0; done_cnt = 0; stall = 0; fin = 0; held = 0;
    for (int cyc = 0; cyc < 30000 && !fin; cyc++) begin
      if (stall) check({name, "_hold"}, {coeff_data, coeff_addr, coeff_last}, held);
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      coeff_ready = ($urandom_range(99) < rdy_pct);
      if (ti < tq.size() && $urandom_range(9) < 8) begin
        sym_valid = 1'b1;
        sym_data  = tq[ti];
      end else begin
        sym_valid = 1'b0;
        sym_data  = 16'($urandom);
      end
      #1;
      if (sym_valid && sym_ready) ti++;
      if (coeff_valid && coeff_ready) begin
        bq_addr.push_back(int'(coeff_addr));
        bq_data.push_back(int'(coeff_data));
        bq_last.push_back(int'(coeff_last));
      end
      stall = coeff_valid && !coeff_ready;
      held  = {coeff_data, coeff_addr, coeff_last};
      @(negedge clk);
    end
    sym_valid = 1'b0;
    check({name, "_finished"}, fin, 1);
    for (int c = 0; c < 3; c++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_idle"}, busy, 0);
    check({name, "_tokens"}, ti, consumed);
    check({name, "_eob_pos"}, eob_pos, idx);
    check({name, "_err"}, err, err_e);
    check({name, "_beats"}, bq_addr.size(), nn);
    for (int k = 0; k < bq_addr.size() && k < nn; k++) begin
      check({name, "_addr"}, bq_addr[k], k);
      check({name, "_data"}, bq_data[k], exp_mem[k]);
      check({name, "_last"}, bq_last[k], (k == nn - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int cnt;
    #23;
    check("rst_busy", busy, 1);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_coeff_valid", coeff_valid, 0);
    check("rst_coeff_last", coeff_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_eob_pos", eob_pos, 0);
    check("rst_coeff_data", coeff_data, 0);
    check("rst_coeff_addr", coeff_addr, 0);

    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      cnt++;
      start = (cnt < 5);
      if (cnt == 20) check("start_in_clear", sym_ready, 0);
      if (!busy) break;
    end
    start = 1'b0;
    check("clear_cycles", cnt, 4096);

    tq = '{tok_lvl(5), tok_run(3), tok_lvl(-2), TOK_EOB_W, tok_lvl(11), tok_lvl(12)};
    run_block(2, 0, 1, 100, "raster4");
    tq = '{tok_lvl(7), tok_lvl(9), TOK_EOB_W};
    run_block(2, 1, 1, 100, "col4");
    tq = '{tok_run(70), tok_lvl(3)};
    run_block(3, 0, 1, 100, "run_ovf");
    tq.delete();
    for (int i = 0; i < 16; i++) tq.push_back(tok_lvl(1));
    tq.push_back(TOK_EOB_W);
    run_block(2, 0, 1, 100, "full4");
    tq = '{TOK_EOB_W};
    run_block(2, 0, 1, 100, "selfclr");
    tq = '{tok_lvl(8191), tok_lvl(-3), tok_lvl(-8192), TOK_EOB_W};
    run_block(2, 0, 1000, 100, "dq");
    tq = '{tok_lvl(4), TOK_RSVD_W, tok_lvl(5)};
    run_block(2, 1, 1, 70, "rsvd");

    for (int b = 0; b < 4; b++) begin
      gen_tokens(16);
      run_block(4, 1'($urandom_range(1)), int'($urandom_range(2000, 1)), 50, "rnd16");
    end
    for (int b = 0; b < 4; b++) begin
      int lg;
      lg = int'($urandom_range(3));
      gen_tokens((lg < 2) ? 4 : (1 << lg));
      run_block(lg, 1'($urandom_range(1)), int'($urandom_range(40, 1)), 60, "rnd_small");
    end
    tq = '{tok_run(4000), tok_lvl(-77), tok_lvl(55), TOK_EOB_W};
    run_block(7, 1, 3, 90, "big64");

    @(negedge clk);
    tx_log2 = 3'd3; scan_col = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sym_valid = 1'b1;
      sym_data  = tok_lvl(99 + i);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_sym_ready", sym_ready, 0);
    check("midrst_coeff_valid", coeff_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("midrst_clear");
    tq = '{TOK_EOB_W};
    run_block(3, 0, 1, 100, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
